// File: rtl/adder_pkg.sv
// Shared helpers for the segmented carry-select adder family.
package adder_pkg;

  function automatic int unsigned nseg(input int unsigned width, input int unsigned seg);
    return width / seg;
  endfunction

  function automatic bit seg_fits(input int unsigned width, input int unsigned seg);
    return (seg != 0) && (width % seg == 0);
  endfunction

endpackage

// File: rtl/select_segment.sv
// One carry-select slice: both carry-in hypotheses for a SEG-bit segment, with overflow terms.
module select_segment #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  output logic [SEG-1:0] sum0_o,
  output logic [SEG-1:0] sum1_o,
  output logic           c0_o,
  output logic           c1_o,
  output logic           ovf0_o,
  output logic           ovf1_o
);

  logic [SEG:0] s0, s1;

  assign s0 = {1'b0, a_i} + {1'b0, b_i};
  assign s1 = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, 1'b1};

  assign sum0_o = s0[SEG-1:0];
  assign sum1_o = s1[SEG-1:0];
  assign c0_o   = s0[SEG];
  assign c1_o   = s1[SEG];
  // Carry into the MSB is recovered from the MSB sum bit.
  assign ovf0_o = (a_i[SEG-1] ^ b_i[SEG-1] ^ s0[SEG-1]) ^ s0[SEG];
  assign ovf1_o = (a_i[SEG-1] ^ b_i[SEG-1] ^ s1[SEG-1]) ^ s1[SEG];

endmodule

// File: rtl/select_adder_pipe.sv
// Pipelined carry-select adder/subtractor: stage 0 precomputes all segment pairs, stage j
// resolves segment j from the carry registered by stage j-1.
module select_adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [CNT_W-1:0] op_count
);

  localparam int NSeg = int'(nseg(WIDTH, SEG));

  if (!seg_fits(WIDTH, SEG)) begin : g_bad_seg
    $error("WIDTH must be a non-zero multiple of SEG");
  end

  typedef struct packed {
    logic [SEG-1:0] sum0;
    logic [SEG-1:0] sum1;
    logic           c0;
    logic           c1;
    logic           ovf0;
    logic           ovf1;
  } seg_pair_t;

  logic             stall, accept, c_eff;
  logic [WIDTH-1:0] b_eff;
  seg_pair_t        pair_in [NSeg];

  logic [NSeg-1:0]  vld_q, vld_d, ld;
  logic [WIDTH-1:0] res_q [NSeg];
  logic [WIDTH-1:0] res_d [NSeg];
  logic             carry_q [NSeg];
  logic             carry_d [NSeg];
  logic             ovf_q [NSeg];
  logic             ovf_d [NSeg];
  seg_pair_t        pair_q [NSeg][NSeg];
  seg_pair_t        pair_d [NSeg][NSeg];
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign stall    = vld_q[NSeg-1] & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  assign b_eff    = sub ? ~b : b;
  assign c_eff    = sub | cin;

  for (genvar k = 0; k < NSeg; k++) begin : g_seg
    select_segment #(.SEG(SEG)) u_seg (
      .a_i    (a[k*SEG +: SEG]),
      .b_i    (b_eff[k*SEG +: SEG]),
      .sum0_o (pair_in[k].sum0),
      .sum1_o (pair_in[k].sum1),
      .c0_o   (pair_in[k].c0),
      .c1_o   (pair_in[k].c1),
      .ovf0_o (pair_in[k].ovf0),
      .ovf1_o (pair_in[k].ovf1)
    );
  end

  always_comb begin
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    pair_d  = pair_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;

    // Data registers load only behind a valid beat so bubbles leave them untouched.
    ld[0] = accept;
    for (int j = 1; j < NSeg; j++) ld[j] = ~stall & vld_q[j-1];
    vld_d = stall ? vld_q : ld;

    if (ld[0]) begin
      pair_d[0]          = pair_in;
      res_d[0]           = '0;
      res_d[0][SEG-1:0]  = c_eff ? pair_in[0].sum1 : pair_in[0].sum0;
      carry_d[0]         = c_eff ? pair_in[0].c1 : pair_in[0].c0;
      ovf_d[0]           = c_eff ? pair_in[0].ovf1 : pair_in[0].ovf0;
    end

    for (int j = 1; j < NSeg; j++) begin
      if (ld[j]) begin
        pair_d[j]               = pair_q[j-1];
        res_d[j]                = res_q[j-1];
        res_d[j][j*SEG +: SEG]  = carry_q[j-1] ? pair_q[j-1][j].sum1 : pair_q[j-1][j].sum0;
        carry_d[j]              = carry_q[j-1] ? pair_q[j-1][j].c1 : pair_q[j-1][j].c0;
        ovf_d[j]                = carry_q[j-1] ? pair_q[j-1][j].ovf1 : pair_q[j-1][j].ovf0;
      end
    end

    if (ld[NSeg-1]) zero_d = (res_d[NSeg-1] == '0);
    if (vld_q[NSeg-1] && out_ready && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      zero_q <= 1'b0;
      cnt_q  <= '0;
      for (int j = 0; j < NSeg; j++) begin
        res_q[j]   <= '0;
        carry_q[j] <= 1'b0;
        ovf_q[j]   <= 1'b0;
        for (int k = 0; k < NSeg; k++) pair_q[j][k] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      pair_q  <= pair_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = vld_q[NSeg-1];
  assign sum       = res_q[NSeg-1];
  assign cout      = carry_q[NSeg-1];
  assign ovf       = ovf_q[NSeg-1];
  assign zero      = zero_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_select_adder_pipe.sv
// Scoreboard bench for select_adder_pipe: a 32/8 instance and a single-stage 16/16 instance.
module tb_select_adder_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b1;
  logic [31:0] a32 = '0, b32 = '0, s32;
  logic        cin32 = 1'b0, sub32 = 1'b0, co32, of32, z32;
  logic [31:0] cnt32;

  logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        cin16 = 1'b0, sub16 = 1'b0, co16, of16, z16;
  logic [31:0] cnt16;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];

  select_adder_pipe #(.WIDTH(32), .SEG(8), .CNT_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(s32),
    .cout(co32), .ovf(of32), .zero(z32), .op_count(cnt32)
  );

  select_adder_pipe #(.WIDTH(16), .SEG(16), .CNT_W(32)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
    .cout(co16), .ovf(of16), .zero(z16), .op_count(cnt16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && ov32 && or32) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL out32_unexpected: got sum 0x%0h, required no output", s32);
      end else begin
        exp_t e;
        e = q32.pop_front();
        check("sum32", 64'(s32), 64'(e.sum));
        check("cout32", 64'(co32), 64'(e.cout));
        check("ovf32", 64'(of32), 64'(e.ovf));
        check("zero32", 64'(z32), 64'(e.zero));
        if (e.lat != 0) check("lat32", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov16 && or16) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL out16_unexpected: got sum 0x%0h, required no output", s16);
      end else begin
        exp_t e;
        e = q16.pop_front();
        check("sum16", 64'(s16), 64'(e.sum));
        check("cout16", 64'(co16), 64'(e.cout));
        check("ovf16", 64'(of16), 64'(e.ovf));
        check("zero16", 64'(z16), 64'(e.zero));
        if (e.lat != 0) check("lat16", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  task automatic drive(input bit w16, input logic [31:0] av, input logic [31:0] bv,
                       input logic cv, input logic sv, input logic [31:0] es,
                       input logic ec, input logic eo, input logic ez, input int lat,
                       input bit push);
    logic rdy;
    int   acc;
    bit   done;
    exp_t e;
    done = 1'b0;
    #1;
    if (w16) begin
      a16 = av[15:0]; b16 = bv[15:0]; cin16 = cv; sub16 = sv; iv16 = 1'b1;
    end else begin
      a32 = av; b32 = bv; cin32 = cv; sub32 = sv; iv32 = 1'b1;
    end
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      rdy = w16 ? ir16 : ir32;
      acc = cyc;
      @(posedge clk);
      done = rdy;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required acceptance");
    end else if (push) begin
      e.sum = es; e.cout = ec; e.ovf = eo; e.zero = ez; e.lat = lat; e.acc = acc;
      if (w16) q16.push_back(e);
      else     q32.push_back(e);
    end
  endtask

  task automatic idle();
    #1;
    iv32 = 1'b0;
    iv16 = 1'b0;
  endtask

  task automatic wait_empty(input bit w16);
    int n;
    n = 0;
    while ((w16 ? q16.size() : q32.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending results, required 0",
               w16 ? q16.size() : q32.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state after idling
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(ov32), 64'(0));
    check("rst_sum", 64'(s32), 64'(0));
    check("rst_op_count", 64'(cnt32), 64'(0));
    check("rst_in_ready", 64'(ir32), 64'(1));
    check("rst_zero", 64'(z32), 64'(0));
    check("rst_cout", 64'(co32), 64'(0));
    @(posedge clk);

    // Full carry ripple across all segments
    drive(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 4, 1'b1);
    idle();
    wait_empty(1'b0);
    check("op_count_1", 64'(cnt32), 64'(1));

    // Subtraction: signed overflow, then borrow
    drive(1'b0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 4, 1'b1);
    drive(1'b0, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 4, 1'b1);
    drive(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0, 4, 1'b1);
    drive(1'b0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 4, 1'b1);
    idle();
    wait_empty(1'b0);
    check("op_count_5", 64'(cnt32), 64'(5));

    // Backpressure on a back-to-back stream
    do_reset();
    fork
      begin
        for (int i = 0; i < 6; i++)
          drive(1'b0, 32'(i), 32'h10, 1'b0, 1'b0, 32'h10 + 32'(i), 1'b0, 1'b0, 1'b0, 0, 1'b1);
        idle();
      end
      begin
        int n;
        n = 0;
        while (!ov32 && n < 50) begin
          @(negedge clk);
          n++;
        end
        if (n >= 50) begin
          checks++; errors++;
          $display("FAIL bp_out_valid: got out_valid=0 for 50 cycles, required 1");
        end
        @(posedge clk);
        #1;
        or32 = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_in_ready", 64'(ir32), 64'(0));
          check("stall_out_valid", 64'(ov32), 64'(1));
        end
        @(posedge clk);
        #1;
        or32 = 1'b1;
      end
    join
    wait_empty(1'b0);
    check("op_count_6", 64'(cnt32), 64'(6));

    // Reset with beats in flight discards them
    drive(1'b0, 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 32'h0000_0007, 32'h0000_0008, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    #1;
    iv32 = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ov32) seen = 1'b1;
    end
    check("flushed_out_valid", 64'(seen), 64'(0));
    check("flushed_op_count", 64'(cnt32), 64'(0));
    @(posedge clk);
    drive(1'b0, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0, 1'b0, 32'hA5A5_5A5A, 1'b0, 1'b0, 1'b0, 4, 1'b1);
    idle();
    wait_empty(1'b0);
    check("op_count_after_flush", 64'(cnt32), 64'(1));

    // Single-stage instance
    drive(1'b1, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    drive(1'b1, 32'h0005, 32'h0005, 1'b0, 1'b1, 32'h0000, 1'b1, 1'b0, 1'b1, 1, 1'b1);
    idle();
    wait_empty(1'b1);
    check("op_count16", 64'(cnt16), 64'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required $finish");
    $fatal(1, "watchdog");
  end

endmodule
